avs_pattern_gen: RTL
====================

Name: avs_pattern_gen

Overview:
- AXI4-Stream video test-pattern source; produces W x H frames, one pixel per beat.
- tuser marks start of frame on the first pixel; tlast marks end of line on the last pixel of each line.
- Sits directly upstream of the stream frame-marker/enforcer stage and drives its tvalid/tready/sof/eol inputs.
- Used for bring-up and for closed-loop verification of downstream video stages.

Parameters:
- W, 16, active pixels per line; must be >= 2.
- H, 8, active lines per frame; must be >= 2.
- B, 0, horizontal blank cycles between lines; tvalid is low during blank.
- V, 0, vertical blank cycles after the last line of a frame.
- DW, 8, tdata width in bits.
- CS, 2, log2 of the checker cell size in pixels.
- Elaboration-time error if W<2, H<2 or DW<1.

Ports:
- aclk, in, 1: clock.
- areset, in, 1: asynchronous reset, active high.
- enable, in, 1: run request; level-sensitive.
- pattern_sel, in, 2: 0 h-ramp, 1 v-ramp, 2 checker, 3 moving ramp.
- tvalid, out, 1: AXIS valid.
- tready, in, 1: AXIS ready.
- tdata, out, DW: pixel value.
- tuser, out, 1: start of frame; high only on pixel (0,0).
- tlast, out, 1: end of line; high on pixel x=W-1.
- frame_done, out, 1: one-cycle pulse when the last pixel of a frame is accepted.
- frame_count, out, 8: frames completed, wrapping at 255->0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, x=0, y=0, frame_count=0. Outputs tvalid, tdata, tuser, tlast and frame_done are all 0. Reset mid-frame aborts the frame with no partial completion.
- States: IDLE, ACTIVE, H_BLANK, V_BLANK. Outputs are registered.
- IDLE:
  - enable sampled high -> ACTIVE.
  - tvalid rises on the next cycle, with pixel (0,0) and tuser=1.
  - pattern_sel is latched on this transition and held for the whole frame.
- ACTIVE:
  - tvalid=1.
  - A beat is accepted when tvalid & tready. Before acceptance, tdata, tuser and tlast are held stable.
  - On accept with x<W-1: x increments and the next pixel appears on the next cycle (back-to-back, one beat per cycle under tready=1).
  - On accept with x=W-1 and y<H-1: x=0, y increments. If B>0 -> H_BLANK; else stay in ACTIVE.
  - On accept with x=W-1 and y=H-1: frame_done pulses on the following cycle and frame_count increments. If V>0 -> V_BLANK; else go to IDLE if enable is low, or restart ACTIVE with a new frame if enable is high.
- H_BLANK: tvalid=0 for exactly B cycles, then ACTIVE.
- V_BLANK:
  - tvalid=0 for exactly V cycles.
  - Then, if enable is high, ACTIVE with a newly latched pattern_sel; if enable is low, IDLE.
- enable low mid-frame: the current frame completes in full. enable is only consulted at frame boundaries.
- tready low: no state or counter advance (blank counters excepted). Blank counters run on every cycle regardless of tready.
- Pixel values, with x and y zero-extended, computed at full width and truncated to the low DW bits:
  - 0: x.
  - 1: y.
  - 2: all-ones if bit 0 of ((x>>CS) ^ (y>>CS)) is 1, else 0.
  - 3: x + frame_count.
- Counter widths: x is $clog2(W) bits, y is $clog2(H) bits, blank counter is $clog2(max(B,V)+1) bits.

Decomposition:
- Package avs_pkg holds:
  - pattern_t enum (H_RAMP, V_RAMP, CHECKER, MOVING).
  - avs_gen_state_t enum.
  - helper function pixel_value(pattern_t, x, y, fc, DW, CS).
- One sub-module is natural: avs_xy_counter (x/y raster counter with advance input and eol/eof flags). It is reusable by downstream checkers.

Test Plan:
- W=4, H=3, B=0, V=0, sel=0, tready=1, enable pulsed for 1 cycle -> 12 consecutive beats with tdata 0,1,2,3 repeating; tuser only on beat 0; tlast on beats 3, 7 and 11; frame_done 1 cycle after beat 11; then tvalid=0 (IDLE).
- Same with B=2, V=3 and enable held high -> 2 tvalid-low cycles between lines; 3 low cycles between frames; second frame starts with tuser=1; frame_count steps 0->1->2.
- sel=2, W=8, H=8, CS=2, DW=8 -> line 0 is 00,00,00,00,FF,FF,FF,FF; line 4 is inverted.
- Random tready at 50% -> every beat's tdata/tuser/tlast is stable while tvalid & !tready; the beat sequence is identical to the tready=1 run.
- areset asserted mid-line (x=2, y=1) -> all outputs 0 immediately (asynchronous); after release with enable high, the frame restarts at (0,0) with tuser=1 and frame_count=0.
- sel=3, 256 back-to-back frames -> frame_count wraps 255->0; the first pixel of each frame equals frame_count mod 2^DW.

Source files
------------

// File: rtl/avs_pkg.sv
// Shared types and the pixel-pattern helper for the AXI4-Stream video
// test-pattern generator and any downstream stage that wants to predict it.
package avs_pkg;

    typedef enum logic [1:0] {
        H_RAMP  = 2'd0,
        V_RAMP  = 2'd1,
        CHECKER = 2'd2,
        MOVING  = 2'd3
    } pattern_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_H_BLANK = 2'd2,
        ST_V_BLANK = 2'd3
    } avs_gen_state_t;

    // Widest pixel the helper can produce, and the width coordinates are
    // zero-extended to before the pattern arithmetic.
    localparam int unsigned PIX_MAXW = 64;
    localparam int unsigned COORD_W  = 32;

    // Pixel value at (x, y) for the selected pattern, computed at full width
    // and masked to the low dw bits. fc is the frame counter (moving ramp).
    function automatic logic [PIX_MAXW-1:0] pixel_value(
        input pattern_t           sel,
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [7:0]         fc,
        input int unsigned        dw,
        input int unsigned        cs
    );
        logic [PIX_MAXW-1:0] full;
        logic [PIX_MAXW-1:0] mask;
        logic                cell_odd;
        full     = {PIX_MAXW{1'b0}};
        cell_odd = (((x >> cs) ^ (y >> cs)) & 32'd1) != 32'd0;
        case (sel)
            H_RAMP:  full = {{(PIX_MAXW-COORD_W){1'b0}}, x};
            V_RAMP:  full = {{(PIX_MAXW-COORD_W){1'b0}}, y};
            CHECKER: full = cell_odd ? {PIX_MAXW{1'b1}} : {PIX_MAXW{1'b0}};
            MOVING:  full = {{(PIX_MAXW-COORD_W){1'b0}}, x} + {{(PIX_MAXW-8){1'b0}}, fc};
            default: full = {PIX_MAXW{1'b0}};
        endcase
        if (dw >= PIX_MAXW) begin
            mask = {PIX_MAXW{1'b1}};
        end else begin
            mask = (64'd1 << dw) - 64'd1;
        end
        return full & mask;
    endfunction

endpackage

// File: rtl/avs_xy_counter.sv
// Raster position counter: x runs 0..W-1, then wraps and bumps y, which runs
// 0..H-1. Exposes the position that will hold after this cycle so a consumer
// can register per-pixel outputs in the same cycle the position moves.
module avs_xy_counter #(
    parameter int W = 16,
    parameter int H = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 advance_i,
    output logic [$clog2(W)-1:0] x_next_o,
    output logic [$clog2(H)-1:0] y_next_o,
    output logic                 eol_o,
    output logic                 eof_o
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // End-of-line / end-of-frame flags for the current position.
    always_comb begin
        eol_o = (x_q == X_LAST);
        eof_o = (x_q == X_LAST) && (y_q == Y_LAST);
    end

    // Next raster position: hold unless advancing, wrap x then y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance_i) begin
            if (x_q == X_LAST) begin
                x_d = {XW{1'b0}};
                if (y_q == Y_LAST) begin
                    y_d = {YW{1'b0}};
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Position register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= {XW{1'b0}};
            y_q <= {YW{1'b0}};
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_next_o = x_d;
    assign y_next_o = y_d;

endmodule

// File: rtl/avs_pattern_gen.sv
// AXI4-Stream video test-pattern source: W x H frames, one pixel per beat,
// tuser on pixel (0,0), tlast on the last pixel of every line, optional
// horizontal and vertical blanking. All stream outputs are registered.
module avs_pattern_gen
    import avs_pkg::*;
#(
    parameter int W  = 16,
    parameter int H  = 8,
    parameter int B  = 0,
    parameter int V  = 0,
    parameter int DW = 8,
    parameter int CS = 2
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          enable,
    input  logic [1:0]    pattern_sel,
    output logic          tvalid,
    input  logic          tready,
    output logic [DW-1:0] tdata,
    output logic          tuser,
    output logic          tlast,
    output logic          frame_done,
    output logic [7:0]    frame_count
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int BV = (B > V) ? B : V;
    localparam int BW = (BV > 0) ? $clog2(BV + 1) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);
    // Blank counters count down to zero, so they load length-1.
    localparam logic [BW-1:0] H_LOAD = BW'((B > 0) ? (B - 1) : 0);
    localparam logic [BW-1:0] V_LOAD = BW'((V > 0) ? (V - 1) : 0);

    if ((W < 2) || (H < 2) || (DW < 1) || (DW > PIX_MAXW)) begin : g_bad_params
        $error("avs_pattern_gen: requires W>=2, H>=2 and 1<=DW<=64");
    end

    avs_gen_state_t state_q, state_d;
    pattern_t       sel_q, sel_d;
    logic [7:0]     fc_q, fc_d;
    logic [BW-1:0]  blank_q, blank_d;
    logic           tvalid_q, tvalid_d;
    logic [DW-1:0]  tdata_q, tdata_d;
    logic           tuser_q, tuser_d;
    logic           tlast_q, tlast_d;
    logic           done_q, done_d;

    logic           accept_s;
    logic           advance_s;
    logic           eol_s;
    logic           eof_s;
    logic [XW-1:0]  x_next_s;
    logic [YW-1:0]  y_next_s;

    avs_xy_counter #(
        .W (W),
        .H (H)
    ) u_xy (
        .clk_i     (aclk),
        .rst_i     (areset),
        .advance_i (advance_s),
        .x_next_o  (x_next_s),
        .y_next_o  (y_next_s),
        .eol_o     (eol_s),
        .eof_o     (eof_s)
    );

    // Sequencing: frame start, per-beat advance, blanking, frame wrap.
    // enable and pattern_sel are only looked at on frame boundaries.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        fc_d      = fc_q;
        blank_d   = blank_q;
        done_d    = 1'b0;
        tvalid_d  = 1'b0;
        advance_s = 1'b0;
        accept_s  = tvalid_q & tready;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_ACTIVE;
                    sel_d    = pattern_t'(pattern_sel);
                    tvalid_d = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                tvalid_d = 1'b1;
                if (accept_s) begin
                    advance_s = 1'b1;
                    if (eof_s) begin
                        done_d = 1'b1;
                        fc_d   = fc_q + 8'd1;
                        if (V > 0) begin
                            state_d  = ST_V_BLANK;
                            blank_d  = V_LOAD;
                            tvalid_d = 1'b0;
                        end else if (enable) begin
                            state_d  = ST_ACTIVE;
                            sel_d    = pattern_t'(pattern_sel);
                        end else begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                        end
                    end else if (eol_s && (B > 0)) begin
                        state_d  = ST_H_BLANK;
                        blank_d  = H_LOAD;
                        tvalid_d = 1'b0;
                    end else begin
                        state_d  = ST_ACTIVE;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_H_BLANK: begin
                if (blank_q == {BW{1'b0}}) begin
                    state_d  = ST_ACTIVE;
                    tvalid_d = 1'b1;
                end else begin
                    blank_d  = blank_q - BW'(1);
                end
            end
            ST_V_BLANK: begin
                if (blank_q == {BW{1'b0}}) begin
                    if (enable) begin
                        state_d  = ST_ACTIVE;
                        sel_d    = pattern_t'(pattern_sel);
                        tvalid_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    blank_d  = blank_q - BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Beat contents for the position that holds next cycle; zero when idle
    // or blanking. Recomputing from an unchanged position keeps a stalled
    // beat stable.
    always_comb begin
        tdata_d = {DW{1'b0}};
        tuser_d = 1'b0;
        tlast_d = 1'b0;
        if (tvalid_d) begin
            tdata_d = DW'(pixel_value(sel_d, COORD_W'(x_next_s), COORD_W'(y_next_s),
                                      fc_d, DW, CS));
            tuser_d = (x_next_s == {XW{1'b0}}) && (y_next_s == {YW{1'b0}});
            tlast_d = (x_next_s == X_LAST);
        end else begin
            tdata_d = {DW{1'b0}};
            tuser_d = 1'b0;
            tlast_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            sel_q    <= H_RAMP;
            fc_q     <= 8'd0;
            blank_q  <= {BW{1'b0}};
            tvalid_q <= 1'b0;
            tdata_q  <= {DW{1'b0}};
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            fc_q     <= fc_d;
            blank_q  <= blank_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
        end
    end

    assign tvalid      = tvalid_q;
    assign tdata       = tdata_q;
    assign tuser       = tuser_q;
    assign tlast       = tlast_q;
    assign frame_done  = done_q;
    assign frame_count = fc_q;

endmodule
